// File: rtl/lsu_mem_ctrl.sv
// RV32I load/store sequencer for a word-only data_mem; sub-word stores are read-modify-write. Accept-to-rsp: load/SW 2, SB/SH 3, error 1.
// One request in flight; the response is held until rsp_ready. Optional counters are enabled with `define LSU_STATS_EN.
module lsu_mem_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              MemWrite,
    output logic              MemRead,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef LSU_STATS_EN
    ,
    output logic [31:0]       stat_loads,
    output logic [31:0]       stat_stores,
    output logic [31:0]       stat_errs
`endif
);

    typedef enum logic [2:0] {IDLE, RD, RMW_RD, RMW_WR, WR, RESP} state_t;

    state_t              state;
    logic                we_q;
    logic [2:0]          f3_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   merge_q;

    logic                req_bad;
    logic [7:0]          rd_byte;
    logic [15:0]         rd_half;
    logic [DATA_W-1:0]   load_ext;
    logic [DATA_W-1:0]   merged;

    // Misalignment is judged against the access size implied by funct3.
    always_comb begin
        req_bad = 1'b0;
        if (req_we) begin
            case (req_funct3)
                3'd0:    req_bad = 1'b0;
                3'd1:    req_bad = req_addr[0];
                3'd2:    req_bad = |req_addr[1:0];
                default: req_bad = 1'b1;
            endcase
        end else begin
            case (req_funct3)
                3'd0, 3'd4: req_bad = 1'b0;
                3'd1, 3'd5: req_bad = req_addr[0];
                3'd2:       req_bad = |req_addr[1:0];
                default:    req_bad = 1'b1;
            endcase
        end
    end

    always_comb begin
        rd_byte = mem_rdata[8*addr_q[1:0] +: 8];
        rd_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (f3_q)
            3'd0:    load_ext = {{24{rd_byte[7]}}, rd_byte};
            3'd1:    load_ext = {{16{rd_half[15]}}, rd_half};
            3'd4:    load_ext = {24'h0, rd_byte};
            3'd5:    load_ext = {16'h0, rd_half};
            default: load_ext = mem_rdata;
        endcase
    end

    always_comb begin
        merged = mem_rdata;
        if (f3_q == 3'd0)
            merged[8*addr_q[1:0] +: 8] = wdata_q[7:0];
        else
            merged[16*addr_q[1] +: 16] = wdata_q[15:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            we_q      <= 1'b0;
            f3_q      <= 3'd0;
            addr_q    <= '0;
            wdata_q   <= '0;
            merge_q   <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q      <= req_we;
                        f3_q      <= req_funct3;
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        rsp_rdata <= '0;
                        rsp_err   <= req_bad;
                        if (req_bad)
                            state <= RESP;
                        else if (!req_we)
                            state <= RD;
                        else if (req_funct3 == 3'd2)
                            state <= WR;
                        else
                            state <= RMW_RD;
                    end
                end
                RD: begin
                    rsp_rdata <= load_ext;
                    state     <= RESP;
                end
                RMW_RD: begin
                    merge_q <= merged;
                    state   <= RMW_WR;
                end
                RMW_WR:  state <= RESP;
                WR:      state <= RESP;
                RESP: begin
                    if (rsp_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes decode straight from state so reset removes them without waiting for a clock.
    assign req_ready = (state == IDLE) && !rst;
    assign rsp_valid = (state == RESP);
    assign MemRead   = (state == RD) || (state == RMW_RD);
    assign MemWrite  = (state == WR) || (state == RMW_WR);
    assign mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
    assign mem_wdata = (state == WR)     ? wdata_q :
                       (state == RMW_WR) ? merge_q : '0;

`ifdef LSU_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_loads  <= 32'd0;
            stat_stores <= 32'd0;
            stat_errs   <= 32'd0;
        end else if (rsp_valid && rsp_ready) begin
            if (rsp_err)
                stat_errs <= stat_errs + 32'd1;
            else if (we_q)
                stat_stores <= stat_stores + 32'd1;
            else
                stat_loads <= stat_loads + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: directed vector table, backpressure and reset corners, then random traffic against a word-array model.
module tb_lsu_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
`ifdef LSU_STATS_EN
    logic [31:0] stat_loads, stat_stores, stat_errs;
`endif

    always #5 clk = ~clk;

    lsu_mem_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .MemWrite(MemWrite), .MemRead(MemRead), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef LSU_STATS_EN
        , .stat_loads(stat_loads), .stat_stores(stat_stores), .stat_errs(stat_errs)
`endif
    );

    // data_mem stand-in: combinational read, write on the clock edge, plus a backdoor port.
    logic [31:0] env_mem [64];
    logic        bk_we = 1'b0;
    logic [5:0]  bk_idx = 6'd0;
    logic [31:0] bk_dat = 32'h0;

    assign mem_rdata = MemRead ? env_mem[mem_addr[7:2]] : 32'h0;

    always @(posedge clk) begin
        if (MemWrite)
            env_mem[mem_addr[7:2]] <= mem_wdata;
        else if (bk_we)
            env_mem[bk_idx] <= bk_dat;
    end

    int          rd_cyc = 0;
    int          wr_cyc = 0;
    int          both_cyc = 0;
    logic [31:0] last_wdata = 32'h0;
    logic [31:0] last_maddr = 32'h0;

    always @(negedge clk) begin
        if (MemRead)  rd_cyc = rd_cyc + 1;
        if (MemWrite) begin
            wr_cyc = wr_cyc + 1;
            last_wdata = mem_wdata;
        end
        if (MemRead && MemWrite) both_cyc = both_cyc + 1;
        if (MemRead || MemWrite) last_maddr = mem_addr;
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    logic [31:0] model_mem [64];

    // Reference: access size from funct3, alignment by modulo, lanes by shift/mask.
    function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                  input logic [31:0] wd, output logic [31:0] e_rd, output logic e_err,
                                  output int e_lat, output int e_nrd, output int e_nwr, output logic [31:0] e_mw);
        int          size;
        int          off;
        logic [31:0] mask;
        logic [31:0] word;
        logic [31:0] val;
        size = 0;
        if (!we) begin
            if (f3 == 3'd0 || f3 == 3'd4) size = 1;
            else if (f3 == 3'd1 || f3 == 3'd5) size = 2;
            else if (f3 == 3'd2) size = 4;
        end else begin
            if (f3 == 3'd0) size = 1;
            else if (f3 == 3'd1) size = 2;
            else if (f3 == 3'd2) size = 4;
        end
        e_err = (size == 0) || ((addr % size) != 0);
        e_rd = 32'h0; e_lat = 1; e_nrd = 0; e_nwr = 0; e_mw = 32'h0;
        if (e_err) return;
        off  = int'(addr % 4);
        mask = (size == 1) ? 32'hFF : (size == 2) ? 32'hFFFF : 32'hFFFF_FFFF;
        word = model_mem[(addr / 4) % 64];
        if (!we) begin
            val = (word >> (8 * off)) & mask;
            if (f3 == 3'd0 && val[7])  val = val | 32'hFFFF_FF00;
            if (f3 == 3'd1 && val[15]) val = val | 32'hFFFF_0000;
            e_rd = val; e_lat = 2; e_nrd = 1;
        end else begin
            if (size == 4) val = wd;
            else val = (word & ~(mask << (8 * off))) | ((wd & mask) << (8 * off));
            model_mem[(addr / 4) % 64] = val;
            e_mw = val; e_nwr = 1;
            e_lat = (size == 4) ? 2 : 3;
            e_nrd = (size == 4) ? 0 : 1;
        end
    endfunction

    task automatic poke(input int idx, input logic [31:0] dat);
        @(negedge clk); #1;
        bk_we = 1'b1; bk_idx = 6'(idx); bk_dat = dat;
        @(negedge clk); #1;
        bk_we = 1'b0;
        model_mem[idx] = dat;
    endtask

    task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                           input int hold, output logic [31:0] o_rd, output logic o_err, output int o_lat,
                           output int o_nrd, output int o_nwr, output logic [31:0] o_mw,
                           output logic [31:0] o_ma, output int o_unstable);
        int rd0, wr0, n;
        @(negedge clk); #1;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); #1; n++; end
        checks++;
        if (!req_ready) begin
            failures++;
            $display("FAIL accept_timeout actual req_ready=0 expected 1");
        end
        rd0 = rd_cyc; wr0 = wr_cyc;
        @(posedge clk);
        @(negedge clk); #1;
        req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        o_lat = 1;
        while (!rsp_valid && o_lat < 20) begin @(negedge clk); #1; o_lat++; end
        o_rd = rsp_rdata; o_err = rsp_err;
        o_nrd = rd_cyc - rd0; o_nwr = wr_cyc - wr0;
        o_mw = last_wdata; o_ma = last_maddr;
        o_unstable = 0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk); #1;
            if (!rsp_valid || rsp_rdata !== o_rd || rsp_err !== o_err || req_ready) o_unstable++;
        end
        rsp_ready = 1'b1;
        @(negedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        err;
        int          lat;
        int          nrd;
        int          nwr;
        logic [31:0] mw;
    } vec_t;

    vec_t tbl [19];

    initial begin
        logic [31:0] a_rd, a_mw, a_ma, e_rd, e_mw;
        logic        a_err, e_err;
        int          a_lat, a_nrd, a_nwr, a_unst, e_lat, e_nrd, e_nwr, n, w0;
        int          n_ld, n_st, n_er, bad_words;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr, wd;
        string       tag;

        tbl[0]  = '{1'b1, 3'd2, 32'd4,  32'h1234ABCD, 32'h0,        1'b0, 2, 0, 1, 32'h1234ABCD};
        tbl[1]  = '{1'b0, 3'd2, 32'd4,  32'h0,        32'h1234ABCD, 1'b0, 2, 1, 0, 32'h0};
        tbl[2]  = '{1'b1, 3'd0, 32'd9,  32'h000000A5, 32'h0,        1'b0, 3, 1, 1, 32'hBEEFA5EF};
        tbl[3]  = '{1'b0, 3'd2, 32'd8,  32'h0,        32'hBEEFA5EF, 1'b0, 2, 1, 0, 32'h0};
        tbl[4]  = '{1'b1, 3'd2, 32'd8,  32'h80F0017F, 32'h0,        1'b0, 2, 0, 1, 32'h80F0017F};
        tbl[5]  = '{1'b0, 3'd0, 32'd8,  32'h0,        32'h0000007F, 1'b0, 2, 1, 0, 32'h0};
        tbl[6]  = '{1'b0, 3'd0, 32'd11, 32'h0,        32'hFFFFFF80, 1'b0, 2, 1, 0, 32'h0};
        tbl[7]  = '{1'b0, 3'd4, 32'd11, 32'h0,        32'h00000080, 1'b0, 2, 1, 0, 32'h0};
        tbl[8]  = '{1'b0, 3'd1, 32'd10, 32'h0,        32'hFFFF80F0, 1'b0, 2, 1, 0, 32'h0};
        tbl[9]  = '{1'b0, 3'd5, 32'd10, 32'h0,        32'h000080F0, 1'b0, 2, 1, 0, 32'h0};
        tbl[10] = '{1'b0, 3'd2, 32'd6,  32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0};
        tbl[11] = '{1'b1, 3'd1, 32'd3,  32'hDEAD5555, 32'h0,        1'b1, 1, 0, 0, 32'h0};
        tbl[12] = '{1'b0, 3'd7, 32'd0,  32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0};
        tbl[13] = '{1'b1, 3'd3, 32'd0,  32'hFFFFFFFF, 32'h0,        1'b1, 1, 0, 0, 32'h0};
        tbl[14] = '{1'b0, 3'd1, 32'd9,  32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0};
        tbl[15] = '{1'b1, 3'd1, 32'd10, 32'h00001111, 32'h0,        1'b0, 3, 1, 1, 32'h1111017F};
        tbl[16] = '{1'b0, 3'd2, 32'd8,  32'h0,        32'h1111017F, 1'b0, 2, 1, 0, 32'h0};
        tbl[17] = '{1'b0, 3'd4, 32'd9,  32'h0,        32'h00000001, 1'b0, 2, 1, 0, 32'h0};
        tbl[18] = '{1'b0, 3'd1, 32'd8,  32'h0,        32'h0000017F, 1'b0, 2, 1, 0, 32'h0};

        // Reset state, with rst still high.
        @(negedge clk); #1;
        chk("rst_req_ready", {31'h0, req_ready}, 32'h0);
        chk("rst_strobes", {28'h0, rsp_valid, rsp_err, MemRead, MemWrite}, 32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        rst = 1'b0;
        #1;
        chk("idle_req_ready", {31'h0, req_ready}, 32'h1);

        for (int i = 0; i < 64; i++) poke(i, $urandom);
        poke(2, 32'hBEEFBEEF);

        for (int i = 0; i < 19; i++) begin
            void'(model(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wd, e_rd, e_err, e_lat, e_nrd, e_nwr, e_mw));
            run_txn(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wd, i % 3,
                    a_rd, a_err, a_lat, a_nrd, a_nwr, a_mw, a_ma, a_unst);
            tag = $sformatf("vec%0d", i);
            chk({tag, "_rdata"}, a_rd, tbl[i].rd);
            chk({tag, "_err"}, {31'h0, a_err}, {31'h0, tbl[i].err});
            chk({tag, "_latency"}, a_lat, tbl[i].lat);
            chk({tag, "_memread_cycles"}, a_nrd, tbl[i].nrd);
            chk({tag, "_memwrite_cycles"}, a_nwr, tbl[i].nwr);
            chk({tag, "_hold_stable"}, a_unst, 0);
            if (tbl[i].nwr > 0) chk({tag, "_mem_wdata"}, a_mw, tbl[i].mw);
            if (tbl[i].nrd + tbl[i].nwr > 0) chk({tag, "_mem_addr"}, a_ma, {tbl[i].addr[31:2], 2'b00});
        end

        // Backpressure: LW 4 held 5 cycles while a second request waits.
        @(negedge clk); #1;
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'd4;
        chk("bp_accept_ready", {31'h0, req_ready}, 32'h1);
        @(posedge clk);
        @(negedge clk); #1;
        req_addr = 32'd8;
        n = 1;
        while (!rsp_valid && n < 20) begin @(negedge clk); #1; n++; end
        chk("bp_latency", n, 2);
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid", {31'h0, rsp_valid}, 32'h1);
            chk("bp_rsp_rdata", rsp_rdata, 32'h1234ABCD);
            chk("bp_req_ready", {31'h0, req_ready}, 32'h0);
            @(negedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(negedge clk); #1;
        rsp_ready = 1'b0;
        chk("bp_next_not_yet_read", {31'h0, MemRead}, 32'h0);
        chk("bp_next_ready", {31'h0, req_ready}, 32'h1);
        @(negedge clk); #1;
        req_valid = 1'b0;
        chk("bp_next_memread", {31'h0, MemRead}, 32'h1);
        chk("bp_next_mem_addr", mem_addr, 32'd8);
        @(negedge clk); #1;
        chk("bp_next_rdata", rsp_rdata, 32'h1111017F);
        rsp_ready = 1'b1;
        @(negedge clk); #1;
        rsp_ready = 1'b0;

        // Reset during RMW_RD of SH 8.
        poke(2, 32'hBEEFBEEF);
        @(negedge clk); #1;
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd1; req_addr = 32'd8; req_wdata = 32'h1111;
        @(posedge clk);
        @(negedge clk); #1;
        req_valid = 1'b0;
        chk("rstmid_in_rmw_rd", {31'h0, MemRead}, 32'h1);
        w0 = wr_cyc;
        rst = 1'b1;
        #1;
        chk("rstmid_memread_drop", {31'h0, MemRead}, 32'h0);
        chk("rstmid_memwrite", {31'h0, MemWrite}, 32'h0);
        chk("rstmid_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rstmid_no_write", wr_cyc - w0, 0);
`ifdef LSU_STATS_EN
        chk("rstmid_stat_loads", stat_loads, 32'h0);
        chk("rstmid_stat_stores", stat_stores, 32'h0);
        chk("rstmid_stat_errs", stat_errs, 32'h0);
`endif
        run_txn(1'b0, 3'd2, 32'd8, 32'h0, 0, a_rd, a_err, a_lat, a_nrd, a_nwr, a_mw, a_ma, a_unst);
        chk("rstmid_lw_after", a_rd, 32'hBEEFBEEF);
        n_ld = 1; n_st = 0; n_er = 0;

        // Random traffic against the model.
        for (int t = 0; t < 250; t++) begin
            we   = 1'($urandom_range(0, 1));
            f3   = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) f3 = {(!we && $urandom_range(0, 1) == 1), 2'($urandom_range(0, 2))};
            if (we && f3 > 3'd2 && $urandom_range(0, 1) == 1) f3 = 3'd0;
            addr = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 1) addr = addr & 32'hFFFF_FFFC;
            wd   = $urandom;
            void'(model(we, f3, addr, wd, e_rd, e_err, e_lat, e_nrd, e_nwr, e_mw));
            run_txn(we, f3, addr, wd, $urandom_range(0, 3), a_rd, a_err, a_lat, a_nrd, a_nwr, a_mw, a_ma, a_unst);
            tag = $sformatf("rnd%0d_we%0d_f%0d_a%0d", t, we, f3, addr);
            chk({tag, "_rdata"}, a_rd, e_rd);
            chk({tag, "_err"}, {31'h0, a_err}, {31'h0, e_err});
            chk({tag, "_latency"}, a_lat, e_lat);
            chk({tag, "_memread_cycles"}, a_nrd, e_nrd);
            chk({tag, "_memwrite_cycles"}, a_nwr, e_nwr);
            chk({tag, "_hold_stable"}, a_unst, 0);
            if (e_nwr > 0) chk({tag, "_mem_wdata"}, a_mw, e_mw);
            if (e_err) n_er++;
            else if (we) n_st++;
            else n_ld++;
        end

        bad_words = 0;
        for (int i = 0; i < 64; i++) if (env_mem[i] !== model_mem[i]) bad_words++;
        chk("final_memory_words_differing", bad_words, 0);
        chk("never_read_and_write", both_cyc, 0);
`ifdef LSU_STATS_EN
        chk("stat_loads", stat_loads, n_ld);
        chk("stat_stores", stat_stores, n_st);
        chk("stat_errs", stat_errs, n_er);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
